sram_mem_responder: RTL and testbench

- Memory-side responder for the MEM-stage data-memory interface.
- Accepts 32-bit word read and write requests (address, write data, read/write enables) from the pipeline.
- Serves each request as two 16-bit accesses to an external asynchronous SRAM.
- Deasserts ready while busy so the top level can freeze the pipeline.

---
 rtl/sram_mem_responder_if.sv | 27 ++
 rtl/sram_mem_responder.sv | 172 +++++++++++++++++
 tb/tb_sram_mem_responder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_mem_responder_if.sv
// sram_mem_responder_if
// Word-wide request/response channel between the pipeline MEM stage and the
// SRAM responder.
//   rd_en, wr_en   : read / write request, held by the initiator until ready
//   address        : byte address of the 32-bit word (word aligned)
//   write_data     : store value
//   read_data      : most recently loaded word
//   ready          : high when no access is in progress or it completes now
// Modports: master = pipeline side, slave = responder side.
interface sram_mem_responder_if;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;

   modport master (
      output rd_en, wr_en, address, write_data,
      input  read_data, ready
   );

   modport slave (
      input  rd_en, wr_en, address, write_data,
      output read_data, ready
   );
endinterface

// File: rtl/sram_mem_responder.sv
// sram_mem_responder
// Serves 32-bit word reads and writes from the pipeline as two 16-bit accesses
// (low half first) to an external asynchronous SRAM. ready is held low while an
// access is in flight so the top level can freeze the pipeline.
// Ports:
//   clk        : system clock
//   rst        : asynchronous reset, active low
//   bus        : request/response channel (slave side)
//   SRAM_DQ    : bidirectional SRAM data bus
//   SRAM_ADDR  : SRAM half-word address
//   SRAM_WE_N  : write strobe, active low
//   SRAM_OE_N  : output enable, active low
//   SRAM_CE_N, SRAM_UB_N, SRAM_LB_N : permanently enabled (tied 0)
module sram_mem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int          WAIT_CYCLES = 2,
   parameter int          SRAM_AW     = 18
) (
   input  logic                clk,
   input  logic                rst,
   sram_mem_responder_if.slave bus,
   inout  wire  [15:0]         SRAM_DQ,
   output logic [SRAM_AW-1:0]  SRAM_ADDR,
   output logic                SRAM_WE_N,
   output logic                SRAM_OE_N,
   output logic                SRAM_CE_N,
   output logic                SRAM_UB_N,
   output logic                SRAM_LB_N
);

   typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

   localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [31:0] offset;
   logic [15:0] dq_out;
   logic        last_cycle;
   logic        latch_req;
   logic        cap_lo, cap_hi;
   logic        dq_drive;
   logic        hi_phase;
   logic        unused_offset_bits;

   assign last_cycle = (cnt_q == LAST_CNT);

   // State and phase counter. The counter only advances inside a phase state
   // and returns to 0 whenever the state changes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Request latch and read-data capture. Each half of read_data is sampled
   // from the bus on the final cycle of its phase, when the SRAM output has
   // had the full wait time to settle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
      end else begin
         if (latch_req) begin
            addr_q  <= bus.address;
            wdata_q <= bus.write_data;
         end
         if (cap_lo) begin
            rdata_q[15:0] <= SRAM_DQ;
         end
         if (cap_hi) begin
            rdata_q[31:16] <= SRAM_DQ;
         end
      end
   end

   // Next-state and SRAM strobe decode. A write takes priority over a read
   // when both are requested. WE_N is released on the last cycle of each write
   // phase so the data is still driven when the SRAM latches it on the rising
   // edge. DONE always returns to IDLE, so a request still held there costs
   // one extra IDLE cycle before its next access starts.
   always_comb begin
      state_d   = state_q;
      cnt_d     = 4'd0;
      latch_req = 1'b0;
      cap_lo    = 1'b0;
      cap_hi    = 1'b0;
      dq_drive  = 1'b0;
      hi_phase  = 1'b0;
      bus.ready = 1'b0;
      SRAM_WE_N = 1'b1;
      SRAM_OE_N = 1'b0;
      case (state_q)
         IDLE: begin
            bus.ready = ~(bus.rd_en | bus.wr_en);
            if (bus.wr_en) begin
               latch_req = 1'b1;
               state_d   = WR_LO;
            end else if (bus.rd_en) begin
               latch_req = 1'b1;
               state_d   = RD_LO;
            end
         end
         RD_LO: begin
            if (last_cycle) begin
               cap_lo  = 1'b1;
               state_d = RD_HI;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         RD_HI: begin
            hi_phase = 1'b1;
            if (last_cycle) begin
               cap_hi  = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         WR_LO: begin
            dq_drive  = 1'b1;
            SRAM_OE_N = 1'b1;
            SRAM_WE_N = last_cycle;
            if (last_cycle) begin
               state_d = WR_HI;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         WR_HI: begin
            hi_phase  = 1'b1;
            dq_drive  = 1'b1;
            SRAM_OE_N = 1'b1;
            SRAM_WE_N = last_cycle;
            if (last_cycle) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DONE: begin
            bus.ready = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Byte offset from the SRAM base, taken modulo 2^32. Bits [SRAM_AW:2] form
   // the word index; higher bits are dropped so the address wraps silently.
   assign offset             = addr_q - BASE_ADDR;
   assign SRAM_ADDR          = {offset[SRAM_AW:2], hi_phase};
   assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

   assign dq_out        = hi_phase ? wdata_q[31:16] : wdata_q[15:0];
   assign SRAM_DQ       = dq_drive ? dq_out : 16'bz;
   assign bus.read_data = rdata_q;

   assign SRAM_CE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_mem_responder.sv
// tb_sram_mem_responder
// Directed bench for sram_mem_responder: a default instance (WAIT_CYCLES=2)
// with a behavioural SRAM, plus a WAIT_CYCLES=4 instance with a read-only SRAM.
module tb_sram_mem_responder;

   logic clk;
   logic rst;
   int   errCount;
   int   checkCount;
   int   cycleCount;

   sram_mem_responder_if bus();
   sram_mem_responder_if bus2();

   wire  [15:0] SRAM_DQ;
   logic [17:0] SRAM_ADDR;
   logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

   wire  [15:0] dq2;
   logic [17:0] addr2;
   logic        we2, oe2, ce2, ub2, lb2;

   logic [15:0] mem  [0:1023];
   logic [15:0] mem2 [0:3];
   logic        quiet;

   sram_mem_responder dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .SRAM_DQ   (SRAM_DQ),
      .SRAM_ADDR (SRAM_ADDR),
      .SRAM_WE_N (SRAM_WE_N),
      .SRAM_OE_N (SRAM_OE_N),
      .SRAM_CE_N (SRAM_CE_N),
      .SRAM_UB_N (SRAM_UB_N),
      .SRAM_LB_N (SRAM_LB_N)
   );

   sram_mem_responder #(.WAIT_CYCLES(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus2),
      .SRAM_DQ   (dq2),
      .SRAM_ADDR (addr2),
      .SRAM_WE_N (we2),
      .SRAM_OE_N (oe2),
      .SRAM_CE_N (ce2),
      .SRAM_UB_N (ub2),
      .SRAM_LB_N (lb2)
   );

   // Clock, 10 ns period, with a free-running cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Behavioural asynchronous SRAM: drives the bus while OE_N is low and WE_N
   // is high; stores the bus value on the rising edge of WE_N. quiet lets the
   // bench release the bus to see whether the responder drives it.
   assign SRAM_DQ = (!quiet && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR[9:0]] : 16'bz;
   always @(posedge SRAM_WE_N) mem[SRAM_ADDR[9:0]] <= SRAM_DQ;

   assign dq2 = (!oe2 && we2) ? mem2[addr2[1:0]] : 16'bz;

   // Watchdog so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // 1 when nobody drives the SRAM bus (reads as Z, or 0 in a two-state sim)
   function automatic logic dqFree();
      return ((SRAM_DQ === 16'h0000) || $isunknown(SRAM_DQ)) ? 1'b1 : 1'b0;
   endfunction

   // Drive one request starting now (just after a rising edge) and hold it
   // until ready is seen. Returns the cycle index of ready (-1 on timeout),
   // the absolute cycle, strobe statistics and SRAM addresses of both phases.
   task automatic applyStimulus(input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output int readyCycle, output int readyAt,
                                output int weLow, output int oeHigh,
                                output logic [17:0] loAddr, output logic [17:0] hiAddr);
      bus.rd_en      = rd;
      bus.wr_en      = wr;
      bus.address    = addr;
      bus.write_data = wdata;
      readyCycle = -1;
      readyAt    = 0;
      weLow      = 0;
      oeHigh     = 0;
      loAddr     = '0;
      hiAddr     = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (!SRAM_WE_N) weLow++;
         if (SRAM_OE_N) oeHigh++;
         if (c == 1) loAddr = SRAM_ADDR;
         if (c == 3) hiAddr = SRAM_ADDR;
         if (bus.ready) begin
            readyCycle = c;
            readyAt    = cycleCount;
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idleBus();
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
   endtask

   initial begin
      int rc, at, we, oe, rc2, at2;
      logic [17:0] lo, hi, lo2, hi2;
      errCount   = 0;
      checkCount = 0;
      cycleCount = 0;
      quiet      = 1'b0;
      rst        = 1'b0;
      bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.address = '0; bus.write_data = '0;
      bus2.rd_en = 1'b0; bus2.wr_en = 1'b0; bus2.address = '0; bus2.write_data = '0;
      mem2[0] = 16'hAAAA; mem2[1] = 16'h5555; mem2[2] = 16'h0000; mem2[3] = 16'h0000;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      quiet = 1'b1;
      #1;
      checkOutput("reset_ready", 32'(bus.ready), 32'd1);
      checkOutput("reset_rdata", bus.read_data, 32'h0);
      checkOutput("reset_we_n", 32'(SRAM_WE_N), 32'd1);
      checkOutput("reset_oe_n", 32'(SRAM_OE_N), 32'd0);
      checkOutput("reset_ce_ub_lb", 32'({SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}), 32'd0);
      checkOutput("reset_dq_free", 32'(dqFree()), 32'd1);
      quiet = 1'b0;
      rst   = 1'b1;
      mem[0] = 16'h5678; mem[1] = 16'h1234; mem[4] = 16'hFFFF; mem[5] = 16'hFFFF;
      @(posedge clk);
      #1;

      // Test 1: basic read of word 0
      applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0, rc, at, we, oe, lo, hi);
      idleBus();
      checkOutput("t1_ready_cycle", 32'(rc), 32'd5);
      checkOutput("t1_lo_addr", 32'(lo), 32'd0);
      checkOutput("t1_hi_addr", 32'(hi), 32'd1);
      checkOutput("t1_rdata", bus.read_data, 32'h12345678);
      checkOutput("t1_we_low", 32'(we), 32'd0);

      // Test 2: write to 1028
      applyStimulus(1'b0, 1'b1, 32'd1028, 32'hCAFEBABE, rc, at, we, oe, lo, hi);
      idleBus();
      checkOutput("t2_ready_cycle", 32'(rc), 32'd5);
      checkOutput("t2_mem2", 32'(mem[2]), 32'h0000BABE);
      checkOutput("t2_mem3", 32'(mem[3]), 32'h0000CAFE);
      checkOutput("t2_we_low", 32'(we), 32'd2);
      checkOutput("t2_oe_high", 32'(oe), 32'd4);
      checkOutput("t2_rdata_kept", bus.read_data, 32'h12345678);
      @(negedge clk);
      quiet = 1'b1;
      #1;
      checkOutput("t2_dq_free", 32'(dqFree()), 32'd1);
      quiet = 1'b0;
      @(posedge clk);
      #1;

      // Test 3: write then read 2000 back-to-back
      applyStimulus(1'b0, 1'b1, 32'd2000, 32'hDEADBEEF, rc, at, we, oe, lo, hi);
      applyStimulus(1'b1, 1'b0, 32'd2000, 32'h0, rc2, at2, we, oe, lo2, hi2);
      idleBus();
      checkOutput("t3_wr_lo_addr", 32'(lo), 32'd488);
      checkOutput("t3_wr_hi_addr", 32'(hi), 32'd489);
      checkOutput("t3_rd_lo_addr", 32'(lo2), 32'd488);
      checkOutput("t3_rd_hi_addr", 32'(hi2), 32'd489);
      checkOutput("t3_rdata", bus.read_data, 32'hDEADBEEF);
      checkOutput("t3_gap", 32'(at2 - at), 32'd6);

      // Test 4: simultaneous read and write requests -> write only
      applyStimulus(1'b1, 1'b1, 32'd1032, 32'h00000001, rc, at, we, oe, lo, hi);
      idleBus();
      checkOutput("t4_ready_cycle", 32'(rc), 32'd5);
      checkOutput("t4_mem4", 32'(mem[4]), 32'h00000001);
      checkOutput("t4_mem5", 32'(mem[5]), 32'h00000000);
      checkOutput("t4_oe_high", 32'(oe), 32'd4);
      checkOutput("t4_rdata_kept", bus.read_data, 32'hDEADBEEF);

      // Test 5: reset in the middle of RD_HI
      bus.rd_en   = 1'b1;
      bus.address = 32'd1024;
      repeat (4) @(negedge clk);
      rst         = 1'b0;
      bus.rd_en   = 1'b0;
      quiet       = 1'b1;
      #1;
      checkOutput("t5_rdata", bus.read_data, 32'h0);
      checkOutput("t5_ready", 32'(bus.ready), 32'd1);
      checkOutput("t5_we_n", 32'(SRAM_WE_N), 32'd1);
      checkOutput("t5_oe_n", 32'(SRAM_OE_N), 32'd0);
      checkOutput("t5_dq_free", 32'(dqFree()), 32'd1);
      quiet = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0, rc, at, we, oe, lo, hi);
      idleBus();
      checkOutput("t5_reissue_cycle", 32'(rc), 32'd5);
      checkOutput("t5_reissue_rdata", bus.read_data, 32'h12345678);

      // Test 6: WAIT_CYCLES=4 read of word 0
      bus2.rd_en   = 1'b1;
      bus2.address = 32'd1024;
      rc = -1;
      we = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (!we2) we++;
         if (bus2.ready) begin
            rc = c;
            break;
         end
      end
      @(posedge clk);
      #1;
      bus2.rd_en = 1'b0;
      checkOutput("t6_ready_cycle", 32'(rc), 32'd9);
      checkOutput("t6_we_low", 32'(we), 32'd0);
      checkOutput("t6_rdata", bus2.read_data, 32'h5555AAAA);

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
